// File: rtl/pipe_sel_ctrl.sv
// Sequencing controller for a 3-stage RV32I pipeline: tracks S2/S3 instructions,
// registers ALU operand selects and forward flags, and raises stall/kill/freeze controls.
module pipe_sel_ctrl #(
  parameter int          FLUSH_CYCLES   = 1,
  parameter bit          LOAD_USE_STALL = 1'b1,
  parameter logic [31:0] NOP            = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_s1,
  input  logic        inst_valid_s1,
  input  logic        br_taken_s2,
  input  logic        mem_ready,
  output logic [31:0] inst_s2,
  output logic [31:0] inst_s3,
  output logic [1:0]  a_sel,
  output logic [1:0]  b_sel,
  output logic        rs1_fwd,
  output logic        rs2_fwd,
  output logic        stall_s1,
  output logic        kill_s1,
  output logic        stall_all,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    FLUSH    = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  // SYSTEM with funct3 != 0 is a CSR access; ecall/ebreak write nothing.
  function automatic logic is_csr(input logic [31:0] i);
    return (i[6:0] == OP_SYSTEM) && (i[14:12] != 3'b000);
  endfunction

  function automatic logic writes_rd(input logic [31:0] i);
    logic cls;
    cls = (i[6:0] == OP_R) || (i[6:0] == OP_IARI) || (i[6:0] == OP_LOAD) ||
          (i[6:0] == OP_LUI) || (i[6:0] == OP_AUIPC) || (i[6:0] == OP_JAL) ||
          (i[6:0] == OP_JALR) || is_csr(i);
    return cls && (i[11:7] != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [31:0] i);
    return (i[6:0] == OP_R) || (i[6:0] == OP_IARI) || (i[6:0] == OP_LOAD) ||
           (i[6:0] == OP_STORE) || (i[6:0] == OP_BRANCH) || (i[6:0] == OP_JALR) ||
           (is_csr(i) && !i[14]);
  endfunction

  function automatic logic uses_rs2(input logic [31:0] i);
    return (i[6:0] == OP_R) || (i[6:0] == OP_STORE) || (i[6:0] == OP_BRANCH);
  endfunction

  function automatic logic is_ctrl(input logic [31:0] i);
    return (i[6:0] == OP_BRANCH) || (i[6:0] == OP_JAL) || (i[6:0] == OP_JALR);
  endfunction

  function automatic logic is_mem(input logic [31:0] i);
    return (i[6:0] == OP_LOAD) || (i[6:0] == OP_STORE);
  endfunction

  function automatic logic a_is_pc(input logic [31:0] i);
    return (i[6:0] == OP_AUIPC) || (i[6:0] == OP_JAL) || (i[6:0] == OP_BRANCH);
  endfunction

  function automatic logic b_is_imm(input logic [31:0] i);
    return (i[6:0] == OP_IARI) || (i[6:0] == OP_LUI) || (i[6:0] == OP_AUIPC) ||
           (i[6:0] == OP_JAL) || (i[6:0] == OP_JALR) || (i[6:0] == OP_BRANCH) ||
           (i[6:0] == OP_STORE) || (i[6:0] == OP_LOAD) || is_csr(i);
  endfunction

  state_t      state_q, state_d, state_view;
  logic [1:0]  flush_cnt, flush_cnt_d;
  logic [31:0] s2_d, s3_d;
  logic        load_s2;
  logic        mem_wait, redirect, load_use;
  logic        stall_s1_c, kill_s1_c, stall_all_c;
  logic        match1, match2;
  logic [1:0]  a_d, b_d;

  assign mem_wait = is_mem(inst_s3) && !mem_ready;
  assign redirect = br_taken_s2 && is_ctrl(inst_s2) && (flush_cnt == 2'd0);
  assign load_use = LOAD_USE_STALL && (inst_s2[6:0] == OP_LOAD) && writes_rd(inst_s2) &&
                    ((uses_rs1(inst_s1) && (inst_s1[19:15] == inst_s2[11:7])) ||
                     (uses_rs2(inst_s1) && (inst_s1[24:20] == inst_s2[11:7])));

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt;
    s2_d        = inst_s2;
    s3_d        = inst_s3;
    load_s2     = 1'b0;
    stall_s1_c  = 1'b0;
    kill_s1_c   = 1'b0;
    stall_all_c = 1'b0;
    // After a memory wait the pending flush count alone says which mode we resume in.
    if (state_q == MEM_WAIT) state_view = (flush_cnt != 2'd0) ? FLUSH : RUN;
    else                     state_view = state_q;
    if (mem_wait) begin
      stall_all_c = 1'b1;
      stall_s1_c  = 1'b1;
      state_d     = MEM_WAIT;
      state_view  = MEM_WAIT;
    end else if (redirect) begin
      kill_s1_c   = 1'b1;
      s3_d        = inst_s2;
      s2_d        = NOP;
      load_s2     = 1'b1;
      flush_cnt_d = FLUSH_INIT;
      state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (flush_cnt != 2'd0) begin
      kill_s1_c   = 1'b1;
      s3_d        = inst_s2;
      s2_d        = NOP;
      load_s2     = 1'b1;
      flush_cnt_d = flush_cnt - 2'd1;
      state_d     = (flush_cnt == 2'd1) ? RUN : FLUSH;
    end else if (load_use) begin
      stall_s1_c = 1'b1;
      s3_d       = inst_s2;
      s2_d       = NOP;
      load_s2    = 1'b1;
      state_d    = RUN;
    end else begin
      s3_d    = inst_s2;
      s2_d    = inst_valid_s1 ? inst_s1 : NOP;
      load_s2 = 1'b1;
      state_d = RUN;
    end
  end

  // Selects are evaluated for the instruction entering S2 against the one entering S3.
  always_comb begin
    match1 = uses_rs1(s2_d) && writes_rd(inst_s2) && (s2_d[19:15] == inst_s2[11:7]);
    match2 = uses_rs2(s2_d) && writes_rd(inst_s2) && (s2_d[24:20] == inst_s2[11:7]);
    a_d    = a_is_pc(s2_d) ? 2'b01 : (match1 ? 2'b10 : 2'b00);
    b_d    = b_is_imm(s2_d) ? 2'b01 : (match2 ? 2'b10 : 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      flush_cnt <= 2'd0;
      inst_s2   <= NOP;
      inst_s3   <= NOP;
      a_sel     <= 2'b00;
      b_sel     <= 2'b01;
      rs1_fwd   <= 1'b0;
      rs2_fwd   <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_cnt <= flush_cnt_d;
      if (load_s2) begin
        inst_s2 <= s2_d;
        inst_s3 <= s3_d;
        a_sel   <= a_d;
        b_sel   <= b_d;
        rs1_fwd <= match1;
        rs2_fwd <= match2;
      end
    end
  end

  assign stall_s1  = stall_s1_c  && !rst;
  assign kill_s1   = kill_s1_c   && !rst;
  assign stall_all = stall_all_c && !rst;
  assign state     = state_view;

endmodule

// File: tb/tb_pipe_sel_ctrl.sv
// Directed bench for pipe_sel_ctrl: a vector table walks forwarding, load-use,
// memory wait and redirect cases; hand sequences cover reset and reset mid-flush.
module tb_pipe_sel_ctrl;

  localparam logic [31:0] NOPI  = 32'h0000_0013;
  localparam logic [31:0] ADD3  = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] ADDI5 = 32'h0011_8293; // addi x5,x3,1
  localparam logic [31:0] LW6   = 32'h0000_A303; // lw   x6,0(x1)
  localparam logic [31:0] ADD7  = 32'h0063_03B3; // add  x7,x6,x6
  localparam logic [31:0] BEQ   = 32'h0000_0463; // beq  x0,x0,8
  localparam logic [31:0] ADD8  = 32'h0031_0433; // add  x8,x2,x3

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_s1;
  logic        inst_valid_s1, br_taken_s2, mem_ready;
  logic [31:0] inst_s2, inst_s3;
  logic [1:0]  a_sel, b_sel, state;
  logic        rs1_fwd, rs2_fwd, stall_s1, kill_s1, stall_all;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  pipe_sel_ctrl #(.FLUSH_CYCLES(2), .LOAD_USE_STALL(1'b1), .NOP(NOPI)) dut (
    .clk(clk), .rst(rst), .inst_s1(inst_s1), .inst_valid_s1(inst_valid_s1),
    .br_taken_s2(br_taken_s2), .mem_ready(mem_ready), .inst_s2(inst_s2),
    .inst_s3(inst_s3), .a_sel(a_sel), .b_sel(b_sel), .rs1_fwd(rs1_fwd),
    .rs2_fwd(rs2_fwd), .stall_s1(stall_s1), .kill_s1(kill_s1),
    .stall_all(stall_all), .state(state)
  );

  typedef struct {
    logic [31:0] in;
    logic        vld, br, mr;
    logic [31:0] e_s2, e_s3;
    logic [1:0]  e_a, e_b;
    logic        e_f1, e_f2, e_st, e_kl, e_sa;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [31:0] in, input logic vld, br, mr,
                              input logic [31:0] s2, s3, input logic [1:0] a, b,
                              input logic f1, f2, st, kl, sa, input logic [1:0] stt);
    vec_t v;
    v.in = in; v.vld = vld; v.br = br; v.mr = mr;
    v.e_s2 = s2; v.e_s3 = s3; v.e_a = a; v.e_b = b;
    v.e_f1 = f1; v.e_f2 = f2; v.e_st = st; v.e_kl = kl; v.e_sa = sa; v.e_state = stt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    check({p, ".inst_s2"},   inst_s2,   v.e_s2);
    check({p, ".inst_s3"},   inst_s3,   v.e_s3);
    check({p, ".a_sel"},     32'(a_sel),     32'(v.e_a));
    check({p, ".b_sel"},     32'(b_sel),     32'(v.e_b));
    check({p, ".rs1_fwd"},   32'(rs1_fwd),   32'(v.e_f1));
    check({p, ".rs2_fwd"},   32'(rs2_fwd),   32'(v.e_f2));
    check({p, ".stall_s1"},  32'(stall_s1),  32'(v.e_st));
    check({p, ".kill_s1"},   32'(kill_s1),   32'(v.e_kl));
    check({p, ".stall_all"}, 32'(stall_all), 32'(v.e_sa));
    check({p, ".state"},     32'(state),     32'(v.e_state));
  endtask

  // Apply inputs just after a rising edge, sample at the falling edge.
  task automatic drive(input logic [31:0] in, input logic vld, br, mr);
    inst_s1 = in; inst_valid_s1 = vld; br_taken_s2 = br; mem_ready = mr;
  endtask

  initial begin
    //           inst   vld br mr  s2     s3     a     b     f1 f2 st kl sa state
    vecs[0]  = mk(ADD3,  1, 0, 1, NOPI,  NOPI,  2'd0, 2'd1, 0, 0, 0, 0, 0, 2'd0);
    vecs[1]  = mk(ADDI5, 1, 0, 1, ADD3,  NOPI,  2'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0);
    vecs[2]  = mk(LW6,   1, 0, 1, ADDI5, ADD3,  2'd2, 2'd1, 1, 0, 0, 0, 0, 2'd0);
    vecs[3]  = mk(ADD7,  1, 0, 1, LW6,   ADDI5, 2'd0, 2'd1, 0, 0, 1, 0, 0, 2'd0);
    vecs[4]  = mk(ADD7,  1, 0, 1, NOPI,  LW6,   2'd0, 2'd1, 0, 0, 0, 0, 0, 2'd0);
    vecs[5]  = mk(LW6,   1, 0, 1, ADD7,  NOPI,  2'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0);
    vecs[6]  = mk(ADDI5, 1, 0, 1, LW6,   ADD7,  2'd0, 2'd1, 0, 0, 0, 0, 0, 2'd0);
    vecs[7]  = mk(BEQ,   1, 0, 0, ADDI5, LW6,   2'd0, 2'd1, 0, 0, 1, 0, 1, 2'd2);
    vecs[8]  = mk(BEQ,   1, 0, 0, ADDI5, LW6,   2'd0, 2'd1, 0, 0, 1, 0, 1, 2'd2);
    vecs[9]  = mk(BEQ,   1, 0, 0, ADDI5, LW6,   2'd0, 2'd1, 0, 0, 1, 0, 1, 2'd2);
    vecs[10] = mk(BEQ,   1, 0, 1, ADDI5, LW6,   2'd0, 2'd1, 0, 0, 0, 0, 0, 2'd0);
    vecs[11] = mk(ADD3,  1, 1, 1, BEQ,   ADDI5, 2'd1, 2'd1, 0, 0, 0, 1, 0, 2'd0);
    vecs[12] = mk(ADD3,  1, 1, 1, NOPI,  BEQ,   2'd0, 2'd1, 0, 0, 0, 1, 0, 2'd1);
    vecs[13] = mk(ADD3,  1, 0, 1, NOPI,  NOPI,  2'd0, 2'd1, 0, 0, 0, 0, 0, 2'd0);
    vecs[14] = mk(ADD8,  1, 0, 1, ADD3,  NOPI,  2'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0);
    vecs[15] = mk(ADDI5, 0, 0, 1, ADD8,  ADD3,  2'd0, 2'd2, 0, 1, 0, 0, 0, 2'd0);
    vecs[16] = mk(ADDI5, 0, 0, 1, NOPI,  ADD8,  2'd0, 2'd1, 0, 0, 0, 0, 0, 2'd0);

    // Reset: held two cycles with inputs that would otherwise provoke controls.
    rst = 1'b1;
    drive(LW6, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst.stall_s1",  32'(stall_s1),  32'd0);
    check("rst.kill_s1",   32'(kill_s1),   32'd0);
    check("rst.stall_all", 32'(stall_all), 32'd0);
    check("rst.inst_s2",   inst_s2, NOPI);
    check("rst.inst_s3",   inst_s3, NOPI);
    check("rst.a_sel",     32'(a_sel), 32'd0);
    check("rst.b_sel",     32'(b_sel), 32'd1);
    check("rst.state",     32'(state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].in, vecs[i].vld, vecs[i].br, vecs[i].mr);
      @(negedge clk);
      check_vec(i, vecs[i]);
      @(posedge clk); #1;
    end

    // Reset arriving in the middle of a flush.
    drive(BEQ, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(ADD3, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("rf.redirect_kill", 32'(kill_s1), 32'd1);
    @(posedge clk); #1;
    check("rf.flush_state", 32'(state), 32'd1);
    check("rf.flush_kill",  32'(kill_s1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rf.rst_kill",  32'(kill_s1),  32'd0);
    check("rf.rst_stall", 32'(stall_s1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(ADD3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("rf.after_state",   32'(state),   32'd0);
    check("rf.after_kill",    32'(kill_s1), 32'd0);
    check("rf.after_inst_s2", inst_s2, NOPI);
    check("rf.after_inst_s3", inst_s3, NOPI);
    check("rf.after_b_sel",   32'(b_sel), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_sel_ctrl.md
Name: pipe_sel_ctrl

Overview:
- Pipeline sequencing controller for the 3-stage RV32I core: S1 fetch/decode, S2 execute, S3 memory/writeback.
- Tracks the instructions occupying S2 and S3, and registers the ALU operand selects (a_sel/b_sel) plus raw forward flags for each instruction entering S2.
- Generates S1 stall, S1 kill and full-pipeline freeze controls for:
  - load-use hazards,
  - taken branch/jump redirects,
  - data-memory wait states.

Parameters:
- FLUSH_CYCLES, 1: number of fetched instructions killed after a redirect (1..3).
- LOAD_USE_STALL, 1: 1 = insert one bubble on load-use; 0 = rely on S3 forwarding of load data.
- NOP, 32'h00000013: bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- inst_s1  in  32  instruction leaving S1.
- inst_valid_s1  in  1  inst_s1 holds a real instruction.
- br_taken_s2  in  1  branch comparator/jump resolved taken for inst_s2.
- mem_ready  in  1  DMEM ready for the load/store in S3.
- inst_s2  out  32  instruction in S2.
- inst_s3  out  32  instruction in S3.
- a_sel  out  2  00 rs1, 01 PC, 10 forward from S3.
- b_sel  out  2  00 rs2, 01 imm, 10 forward from S3.
- rs1_fwd  out  1  S2 rs1 matches S3 rd (branch compare / store data).
- rs2_fwd  out  1  S2 rs2 matches S3 rd.
- stall_s1  out  1  hold PC and S1 register.
- kill_s1  out  1  replace inst_s1 with NOP on advance.
- stall_all  out  1  freeze PC, S1, S2, S3.
- state  out  2  00 RUN, 01 FLUSH, 10 MEM_WAIT (debug).

Behaviour:

Reset (rst high at posedge):
- inst_s2 = inst_s3 = NOP.
- a_sel = 00, b_sel = 01, rs1_fwd = rs2_fwd = 0.
- flush_cnt = 0, state = RUN.
- stall_s1, kill_s1 and stall_all are 0 while rst is high.
- rst mid-flush or mid-wait aborts the sequence immediately.

Decode classes:
- writes_rd: R, I-ARI, LOAD, LUI, AUIPC, JAL, JALR, CSR; only when rd != 0.
- uses_rs1: R, I-ARI, LOAD, STORE, BRANCH, JALR, and CSR with funct3[2]=0.
- uses_rs2: R, STORE, BRANCH.
- ctrl: BRANCH, JAL, JALR.

Per-cycle priority (stall_s1, kill_s1 and stall_all are combinational, same cycle):
1. MEM_WAIT condition: inst_s3 is LOAD/STORE and mem_ready=0.
   - stall_all=1, stall_s1=1.
   - All registers hold, state=MEM_WAIT.
   - Redirects and hazards are not evaluated.
   - Leaves MEM_WAIT in the cycle mem_ready=1.
2. Redirect: br_taken_s2 && ctrl(inst_s2) && flush_cnt==0.
   - kill_s1=1; inst_s3<=inst_s2; inst_s2<=NOP.
   - flush_cnt<=FLUSH_CYCLES-1.
   - state<=FLUSH if FLUSH_CYCLES>1, else RUN.
3. FLUSH (flush_cnt>0):
   - kill_s1=1; advance with NOP into S2; flush_cnt decrements.
   - Returns to RUN when flush_cnt reaches 0.
   - br_taken_s2 is ignored, since inst_s2 is NOP.
4. Load-use (LOAD_USE_STALL=1): inst_s2 is LOAD, writes_rd, and inst_s1 uses rs1/rs2 equal to that rd.
   - stall_s1=1; inst_s3<=inst_s2; inst_s2<=NOP.
   - Lasts exactly one cycle.
   - The register file is write-first, so S1 captures the load result during the stall.
5. Normal:
   - inst_s3<=inst_s2.
   - inst_s2<=inst_valid_s1 ? inst_s1 : NOP.

Select registers:
- Loaded whenever S2 loads. Computed from next inst_s2 against next inst_s3 (current inst_s2).
- match1 = uses_rs1 && writes_rd(S3) && rs1==rd(S3); match2 is analogous for rs2.
- a_sel: 01 for AUIPC, JAL, BRANCH; else 10 if match1; else 00.
- b_sel: 01 for I-ARI, LUI, AUIPC, JAL, JALR, BRANCH, STORE, LOAD, CSR; else 10 if match2; else 00.
- rs1_fwd = match1, rs2_fwd = match2.
- Bubbles produce a_sel=00, b_sel=01, flags 0.
- Everything holds during stall_all.
- Latency: selects are valid the same cycle the instruction appears on inst_s2.

Test Plan:
1. Reset: hold rst 2 cycles, then inst_s1 = 0x002081B3 (add x3,x1,x2) -> next cycle inst_s2 = 0x002081B3, a_sel=00, b_sel=00, inst_s3 = NOP, no stalls.
2. ALU forward: 0x002081B3 then 0x00118293 (addi x5,x3,1) -> when addi is in S2: a_sel=10, b_sel=01, rs1_fwd=1.
3. Load-use: 0x0000A303 (lw x6) then 0x006303B3 (add x7,x6,x6) -> one cycle with stall_s1=1 and inst_s2=NOP; next cycle add is in S2, a_sel=00, b_sel=00 (load already retired).
4. Redirect with FLUSH_CYCLES=2: 0x00000463 (beq x0,x0,8) in S2 with br_taken_s2=1 -> kill_s1=1 for 2 consecutive cycles, state 01 then 00, inst_s2=NOP both cycles.
5. Memory wait: lw in S3, mem_ready=0 for 3 cycles -> stall_all=1 for exactly 3 cycles; inst_s2, inst_s3 and selects unchanged; state=10; resumes when mem_ready=1.
6. rst asserted mid-FLUSH -> next cycle state=00, kill_s1=0, inst_s2 = inst_s3 = NOP.
